// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Bundles the issue/result signals between the EX stage and the iterative
// multiply/divide unit.
//   master : pipeline side (drives start_i, op_i, abort_i, data_1, data_2)
//   slave  : muldiv_unit   (drives busy_o, done_o, dz_o, hi_o, lo_o)
// Parameter width : operand and HI/LO width.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(parameter int width = 32);
    logic             start_i;
    logic [2:0]       op_i;
    logic             abort_i;
    logic [width-1:0] data_1;
    logic [width-1:0] data_2;
    logic             busy_o;
    logic             done_o;
    logic             dz_o;
    logic [width-1:0] hi_o;
    logic [width-1:0] lo_o;

    modport master (
        output start_i, op_i, abort_i, data_1, data_2,
        input  busy_o, done_o, dz_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, abort_i, data_1, data_2,
        output busy_o, done_o, dz_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with HI/LO registers, sitting beside EX.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU restoring shift-subtract, one bit
// per clock over `width` cycles, followed by one sign-fixup cycle (FIX).
// MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-low reset
//   bus      : muldiv_unit_if.slave
//              start_i/op_i/abort_i/data_1/data_2 in,
//              busy_o/done_o/dz_o/hi_o/lo_o out
//
// Configuration macro: MULDIV_DIV_EN
//   defined   -> DIV/DIVU supported, dz_o reports divide-by-zero
//   undefined -> divider compiled out, DIV/DIVU ignored, dz_o tied 0
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int width = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(width + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               r_state, w_state_nx;
    logic [2*width-1:0]   r_acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [width-1:0]     r_opnd;    // multiplicand or divisor magnitude
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_q;   // negate product / quotient
    logic [width-1:0]     r_hi, r_lo;
    logic                 r_busy, r_done;

    logic                 w_idle, w_go, w_accept;
    logic                 w_op_mul, w_op_div, w_op_signed, w_div_zero;
    logic [width-1:0]     w_abs_a, w_abs_b;
    logic [width:0]       w_mul_sum;
    logic [2*width-1:0]   w_step_nx;
    logic [2*width-1:0]   w_result;  // {HI, LO} written at FIX
    logic [2*width-1:0]   w_prod;

    // ---------------- decode ----------------
    assign w_op_mul    = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
    assign w_op_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    assign w_idle      = (r_state == IDLE);
    assign w_go        = w_idle && bus.start_i && !bus.abort_i;
    assign w_accept    = w_go && (w_op_mul || w_op_div);

    assign w_abs_a = (w_op_signed && bus.data_1[width-1]) ? -bus.data_1 : bus.data_1;
    assign w_abs_b = (w_op_signed && bus.data_2[width-1]) ? -bus.data_2 : bus.data_2;

    // Multiply step: add multiplicand into upper half if LSB set, shift right.
    assign w_mul_sum = {1'b0, r_acc[2*width-1:width]}
                     + ({(width+1){r_acc[0]}} & {1'b0, r_opnd});
    assign w_prod    = r_neg_q ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
    logic                 r_is_div;
    logic                 r_neg_r;   // remainder follows dividend sign
    logic                 r_dz_pend; // divide-by-zero in flight
    logic                 r_dz;
    logic [width:0]       w_div_rem;
    logic [width-1:0]     w_div_sub;
    logic                 w_div_ok;
    logic [width-1:0]     w_quo, w_rem;

    assign w_op_div   = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
    assign w_div_zero = w_op_div && (bus.data_2 == '0);

    // Restoring divide step on the left-shifted partial remainder. The
    // remainder stays below the divisor, so the shifted value fits width+1
    // bits and a successful subtraction fits width bits.
    assign w_div_rem = r_acc[2*width-1:width-1];
    assign w_div_ok  = (w_div_rem >= {1'b0, r_opnd});
    assign w_div_sub = w_div_rem[width-1:0] - r_opnd;

    assign w_quo = r_neg_q ? -r_acc[width-1:0]       : r_acc[width-1:0];
    assign w_rem = r_neg_r ? -r_acc[2*width-1:width] : r_acc[2*width-1:width];

    always_comb begin
        w_step_nx = {w_mul_sum, r_acc[width-1:1]};
        if (r_is_div)
            w_step_nx = {(w_div_ok ? w_div_sub : w_div_rem[width-1:0]),
                         r_acc[width-2:0], w_div_ok};
    end

    always_comb begin
        w_result = w_prod;
        if (r_dz_pend)
            w_result = {r_acc[2*width-1:width], {width{1'b1}}};  // HI = raw dividend
        else if (r_is_div)
            w_result = {w_rem, w_quo};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_div  <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            r_is_div  <= w_op_div;
            r_neg_r   <= w_op_signed && bus.data_1[width-1];
            r_dz_pend <= w_div_zero;
            r_dz      <= 1'b0;
        end else if (r_state == FIX && !bus.abort_i) begin
            r_dz      <= r_dz_pend;
        end
    end

    assign bus.dz_o = r_dz;
`else
    assign w_op_div   = 1'b0;
    assign w_div_zero = 1'b0;
    assign w_step_nx  = {w_mul_sum, r_acc[width-1:1]};
    assign w_result   = w_prod;
    assign bus.dz_o   = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = w_div_zero ? FIX : CALC;
            CALC:    if (bus.abort_i)                      w_state_nx = IDLE;
                     else if (r_cnt == CW'(width - 1))     w_state_nx = FIX;
            FIX:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != IDLE);
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_neg_q <= w_op_signed && (bus.data_1[width-1] ^ bus.data_2[width-1]);
                        r_opnd  <= w_op_div ? w_abs_b : w_abs_a;
                        if (w_div_zero)
                            r_acc <= {bus.data_1, {width{1'b0}}};
                        else
                            r_acc <= {{width{1'b0}}, (w_op_div ? w_abs_a : w_abs_b)};
                    end else if (w_go && bus.op_i == OP_MTHI) begin
                        r_hi <= bus.data_1;
                    end else if (w_go && bus.op_i == OP_MTLO) begin
                        r_lo <= bus.data_1;
                    end
                end
                CALC: begin
                    if (!bus.abort_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_acc <= w_step_nx;
                    end
                end
                FIX: begin
                    if (!bus.abort_i) begin
                        r_done       <= 1'b1;
                        {r_hi, r_lo} <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: reset state, a table of directed
// vectors, hand-written abort / busy-start / reset-mid-op sequences, and
// randomized operations against an arithmetic reference model.
// Adapts to the MULDIV_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.width(W)) bus();
    muldiv_unit #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          cyc;
        logic [31:0] hi, lo;
        logic        dz;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, b,
                                input int cyc, input logic [31:0] hi, lo,
                                input logic dz, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cyc = cyc; v.hi = hi; v.lo = lo; v.dz = dz; v.nm = nm;
        return v;
    endfunction

    // Arithmetic reference: updates model HI/LO/dz and returns busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, b, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        cyc = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 0; cyc = 33; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 0; cyc = 33; end
`ifdef MULDIV_DIV_EN
            3'd3, 3'd4: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a; m_dz = 1; cyc = 1;
                end else begin
                    if (op == 3'd4) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 0; cyc = 33;
                end
            end
`endif
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, measure busy length, then compare outputs.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input int exp_cyc,
                          input logic [31:0] ehi, elo, input logic edz, input string nm);
        int n;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.data_1 = a; bus.data_2 = b;
        @(negedge clk);
        bus.start_i = 1'b0; bus.op_i = 3'd0;
        bus.data_1 = $urandom; bus.data_2 = $urandom;  // operands only valid at E0
        n = 0;
        while (bus.busy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, 64'(n), 64'(exp_cyc));
        check({nm, " done"}, 64'(bus.done_o), 64'(exp_cyc > 0));
        check({nm, " hi"}, 64'(bus.hi_o), 64'(ehi));
        check({nm, " lo"}, 64'(bus.lo_o), 64'(elo));
        check({nm, " dz"}, 64'(bus.dz_o), 64'(edz));
        @(negedge clk);
        check({nm, " done_drop"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nd;
        logic [2:0]  op;
        logic [31:0] a, b;

        bus.start_i = 1'b0; bus.op_i = 3'd0; bus.abort_i = 1'b0;
        bus.data_1 = '0; bus.data_2 = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst busy", 64'(bus.busy_o), 0);
        check("rst done", 64'(bus.done_o), 0);
        check("rst dz",   64'(bus.dz_o), 0);
        check("rst hi",   64'(bus.hi_o), 0);
        check("rst lo",   64'(bus.lo_o), 0);
        rst = 1'b1;

        // ---- directed table ----
        tbl.push_back(mk(3'd1, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mult_7x-3"));
        tbl.push_back(mk(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 0, "multu_max"));
        tbl.push_back(mk(3'd6, 32'h1234, 32'h0, 0, 32'hFFFFFFFE, 32'h1234, 0, "mtlo"));
        tbl.push_back(mk(3'd5, 32'hABCD, 32'h0, 0, 32'hABCD, 32'h1234, 0, "mthi"));
        tbl.push_back(mk(3'd7, 32'h1, 32'h1, 0, 32'hABCD, 32'h1234, 0, "op111"));
        tbl.push_back(mk(3'd0, 32'h1, 32'h1, 0, 32'hABCD, 32'h1234, 0, "op000"));
`ifdef MULDIV_DIV_EN
        tbl.push_back(mk(3'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_-7/2"));
        tbl.push_back(mk(3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0, "divu_100/7"));
        tbl.push_back(mk(3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 0, "div_ovf"));
        tbl.push_back(mk(3'd3, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1, "div_by0"));
        tbl.push_back(mk(3'd5, 32'h55, 32'd0, 0, 32'h55, 32'hFFFFFFFF, 1, "mthi_keep_dz"));
        tbl.push_back(mk(3'd1, 32'd3, 32'd4, 33, 32'd0, 32'd12, 0, "mult_clr_dz"));
`else
        tbl.push_back(mk(3'd3, 32'd5, 32'd0, 0, 32'hABCD, 32'h1234, 0, "div_ignored"));
        tbl.push_back(mk(3'd4, 32'd100, 32'd7, 0, 32'hABCD, 32'h1234, 0, "divu_ignored"));
        tbl.push_back(mk(3'd1, 32'd3, 32'd4, 33, 32'd0, 32'd12, 0, "mult_3x4"));
`endif
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cyc,
                   tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].nm);
            m_hi = tbl[i].hi; m_lo = tbl[i].lo; m_dz = tbl[i].dz;
        end

        // ---- abort mid-multiply, start while busy ignored ----
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd1; bus.data_1 = 32'h1111; bus.data_2 = 32'h2222;
        @(negedge clk);                         // after E0
        bus.start_i = 1'b0; bus.op_i = 3'd0;
        repeat (4) @(negedge clk);              // after E4
        bus.start_i = 1'b1; bus.op_i = 3'd6; bus.data_1 = 32'hDEAD;
        @(negedge clk);                         // after E5
        bus.start_i = 1'b0; bus.op_i = 3'd0;
        repeat (5) @(negedge clk);              // after E10
        check("abort pre busy", 64'(bus.busy_o), 1);
        bus.abort_i = 1'b1;
        @(negedge clk);                         // after E11
        bus.abort_i = 1'b0;
        check("abort busy", 64'(bus.busy_o), 0);
        check("abort done", 64'(bus.done_o), 0);
        check("abort hi", 64'(bus.hi_o), 64'(m_hi));
        check("abort lo", 64'(bus.lo_o), 64'(m_lo));
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) nd++;
        end
        check("abort no_late_done", 64'(nd), 0);

        // ---- abort wins over start in IDLE ----
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd5; bus.data_1 = 32'h77; bus.abort_i = 1'b1;
        @(negedge clk);
        check("idle_abort mthi", 64'(bus.hi_o), 64'(m_hi));
        bus.op_i = 3'd1;
        @(negedge clk);
        check("idle_abort mult busy", 64'(bus.busy_o), 0);
        bus.start_i = 1'b0; bus.op_i = 3'd0; bus.abort_i = 1'b0;

        // ---- reset during an operation ----
        @(negedge clk);
        bus.start_i = 1'b1; bus.data_1 = 32'd100; bus.data_2 = 32'd7;
`ifdef MULDIV_DIV_EN
        bus.op_i = 3'd3;
`else
        bus.op_i = 3'd1;
`endif
        @(negedge clk);
        bus.start_i = 1'b0; bus.op_i = 3'd0;
        repeat (4) @(negedge clk);              // after E4
        rst = 1'b0;
        @(negedge clk);                         // after E5
        check("midrst busy", 64'(bus.busy_o), 0);
        check("midrst done", 64'(bus.done_o), 0);
        check("midrst dz",   64'(bus.dz_o), 0);
        check("midrst hi",   64'(bus.hi_o), 0);
        check("midrst lo",   64'(bus.lo_o), 0);
        rst = 1'b1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;

        // ---- randomized ops against the reference model ----
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(1, 6));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                2: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            model(op, a, b, cyc);
            run_op(op, a, b, cyc, m_hi, m_lo, m_dz, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, attached beside the EX stage of the five-stage MIPS pipeline. It takes the forwarded EX operands (outputs of the Data_1/Data_2 forwarding muxes) when the decoder issues a MULT/MULTU/DIV/DIVU/MTHI/MTLO. It computes over multiple cycles and raises `busy_o`, which the hazard logic uses to stall IF/ID/EX. HI/LO feed the MFHI/MFLO path into the EX/MEM ALU-output latch.

## Interface
Parameters:
- `width`, 32, operand and HI/LO width; iteration count equals `width`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low.
- `start_i`  in  1  issue strobe; sampled with `op_i` on a rising edge.
- `op_i`  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
- `abort_i`  in  1  pipeline flush; cancels an in-flight operation.
- `data_1`  in  width  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `data_2`  in  width  rt operand: multiplier or divisor.
- `busy_o`  out  1  operation in flight; the pipeline must stall.
- `done_o`  out  1  one-cycle pulse when HI/LO take a mul/div result.
- `dz_o`  out  1  last divide had divisor 0; holds until the next accepted start.
- `hi_o`  out  width  HI register.
- `lo_o`  out  width  LO register.

## Operation
- FSM states are IDLE, CALC, FIX. Reset (`rst`=0 at an edge) forces IDLE, HI=LO=0, `busy_o`=0, `done_o`=0, `dz_o`=0, and counter=0.
- IDLE: an edge with `start_i`=1 and a mul/div op, with `abort_i`=0, is the accept edge E0.
  - E0 latches operand magnitudes; signed ops take the absolute value of each operand.
  - E0 latches the result-sign flags and clears `dz_o`.
  - Then state goes to CALC and the counter goes to 0.
- MTHI/MTLO in IDLE write `data_1` into HI/LO at E0. They do not assert busy or done.
- Op 000, op 111, or `start_i`=0: no effect.
- `start_i` while busy: ignored and not queued. The hazard logic never issues it.
- CALC (multiply): radix-2 shift-add, one bit per edge over a 2×width accumulator.
- CALC (divide): restoring shift-subtract, one quotient bit per edge.
- CALC exits after `width` edges (E1..E32); state becomes FIX.
- FIX (edge E33): writes signed results to HI/LO, pulses `done_o`, returns to IDLE.
  - Signed mul: negate the 64-bit product if the operand signs differ.
  - Signed div: quotient is negated if the signs differ, truncated toward zero.
  - Signed div: the remainder takes the dividend's sign.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide overflow (0x80000000 / 0xFFFFFFFF, DIV) gives LO=0x80000000, HI=0. This falls out of magnitude arithmetic without special casing.
- Divide by zero: detected at E0.
  - FSM skips CALC and goes directly to FIX.
  - At E1: LO=0xFFFFFFFF, HI=`data_1` as latched, `dz_o`=1, `done_o` pulses.
- `abort_i`=1 in CALC or FIX: next edge returns to IDLE, HI/LO unchanged, no `done_o`.
- `abort_i` together with `start_i` in IDLE: abort wins and nothing is accepted.
- Reset mid-operation: identical to power-on reset; the partial result is discarded.

## Timing
- `busy_o` is registered. It is high from after E0 until E33, i.e. 33 cycles for mul/div (1 cycle for divide-by-zero).
- `done_o` is high for exactly the one cycle following E33 (E1 for divide-by-zero). `busy_o` is 0 in that same cycle.
- HI/LO are valid from the cycle after E33. MFHI issued in that cycle reads the new value with no extra stall.
- MTHI/MTLO take effect the cycle after E0.
- Operands need only be valid at E0; they are not re-read afterwards.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU are supported as above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath and divide-by-zero logic are compiled out, and `dz_o` is tied 0.
  - DIV/DIVU are treated like op 111 (ignored: no busy, HI/LO unchanged).
  - MULT/MULTU/MTHI/MTLO behave identically.

## Test plan
- MULT, `data_1`=7, `data_2`=0xFFFFFFFD (-3) -> `busy_o` high 33 cycles; `done_o` after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MTLO 0x1234 -> LO=0x1234 next cycle, HI unchanged, `done_o` stays 0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 5 / 0 -> `done_o` the cycle after E1, LO=0xFFFFFFFF, HI=5, `dz_o`=1; next MULT start clears `dz_o`.
- MULT started, `abort_i` at E10 -> IDLE after E11, `busy_o`=0, HI/LO hold prior values, no `done_o`; `start_i` during busy ignored.
- `rst`=0 at E5 of a DIV -> next cycle all outputs 0; with `MULDIV_DIV_EN` undefined, DIV start gives `busy_o`=0 and HI/LO unchanged.
